// File: rtl/rv32i_pkg.sv
// rv32i_pkg: constants and types shared across the RV32I core.
//   XLEN             - architectural register/address width
//   NOP_INSTR        - canonical NOP (addi x0, x0, 0)
//   DEFAULT_RESET_PC - PC of the first fetch after reset unless overridden
//   OPC_*            - major opcodes used by decode and fetch-side checks
//   fetch_entry_t    - {pc, instr} pair carried from fetch to decode
//   align_word()     - clears the byte-offset bits of an address
package rv32i_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of {pc, instr} entries.
//   clk, rst  - clock, synchronous active-high reset (empties the FIFO)
//   push      - write wdata this cycle
//   pop       - discard head this cycle (ignored when empty)
//   flush     - empty the FIFO; overrides push and pop in the same cycle
//   wdata     - entry to write
//   rdata     - current head entry (meaningful only when !empty)
//   count     - number of stored entries
//   full      - count == DEPTH
//   empty     - count == 0
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = push & ~flush;
  assign w_do_pop  = pop & ~flush & (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (w_do_push && !rst) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == LP_FULL);
  assign empty = (r_count == '0);

  // The fetch credit scheme must never let a response land in a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !flush && full));

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I instruction fetch stage.
//   clk, rst                        - clock, synchronous active-high reset
//   imem_req_valid/ready/addr       - word request channel to instruction memory
//   imem_rsp_valid/data             - in-order responses, latency >= 1, no back-pressure
//   redirect_valid/pc               - taken branch/jump from execute; flushes the stage
//   instr_valid/ready, Instr/instr_pc - {instruction, pc} handshake to decode
// Handshakes: a transfer happens in a cycle where valid and ready are both 1.
// valid never depends on ready. imem_req_valid may drop without a transfer
// (redirect), so the memory must not assume a valid request stays up.
// Credits: a request is issued only while outstanding + fifo_count < FIFO_DEPTH,
// which reserves a FIFO slot for every in-flight response.
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] instr_pc
);

  localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   LP_DEPTH = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;

  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_wr_entry;
  logic [CW:0]   w_credit_used;
  logic          w_req_accept;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_rsp_dec;
  logic [CW-1:0] w_acc_inc;
  logic [31:0]   w_rsp_pc;

  assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign imem_req_valid = ~rst & ~redirect_valid & (w_credit_used < LP_DEPTH);
  assign imem_req_addr  = rst ? RESET_PC : r_fetch_pc;
  assign w_req_accept   = imem_req_valid & imem_req_ready;

  assign w_rsp_dec = {{(CW-1){1'b0}}, imem_rsp_valid};
  assign w_acc_inc = {{(CW-1){1'b0}}, w_req_accept};

  // The oldest in-flight request sits outstanding words behind fetch_pc.
  assign w_rsp_pc   = r_fetch_pc - {{(30-CW){1'b0}}, r_outstanding, 2'b00};
  assign w_wr_entry = '{pc: w_rsp_pc, instr: imem_rsp_data};

  // Stale responses (drop_cnt > 0) and the response of a redirect cycle are discarded.
  assign w_push = ~rst & imem_rsp_valid & (r_drop_cnt == '0) & ~redirect_valid;
  assign w_pop  = instr_valid & instr_ready;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata (w_wr_entry),
    .rdata (w_head),
    .count (w_fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Gated by rst so the outputs are clean during the first reset cycle too.
  assign instr_valid = ~rst & ~w_fifo_empty;
  assign Instr       = instr_valid ? w_head.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? w_head.pc    : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this edge is stale.
      r_fetch_pc    <= align_word(redirect_pc);
      r_outstanding <= r_outstanding - w_rsp_dec;
      r_drop_cnt    <= r_outstanding - w_rsp_dec;
    end else begin
      if (w_req_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
      r_outstanding <= r_outstanding + w_acc_inc - w_rsp_dec;
      if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

  a_drop_le_out: assert property (@(posedge clk) disable iff (rst) r_drop_cnt <= r_outstanding);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import rv32i_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] Instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .Instr          (Instr),
    .instr_pc       (instr_pc)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  pend_t       pend_q[$];   // memory's in-flight requests (includes stale ones)
  logic [31:0] exp_q[$];    // PCs the decoder must still receive, in order
  int          buf_cnt;     // how many of exp_q's front entries have data buffered
  logic [31:0] exp_pc;
  int          cyc;
  int          last_due;
  int          n_vec;
  int          n_err;

  // stimulus knobs
  int          lat_min, lat_max, p_mready, p_iready, p_redir;
  bit          drv_rst;
  bit          drv_redir;
  logic [31:0] drv_rpc;

  // observation logs of DUT transfers
  logic [31:0] acc_log[$];
  int          acc_cyc[$];
  logic [31:0] pop_log[$];
  int          pop_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] + a[9:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, expv);
    end
  endtask

  task automatic clear_logs();
    acc_log.delete(); acc_cyc.delete(); pop_log.delete(); pop_cyc.delete();
  endtask

  // ---------------- driver + per-cycle compare ----------------
  task automatic step();
    bit          rsp;
    bit          e_rv, e_iv;
    logic [31:0] e_addr, e_instr, e_pc;
    pend_t       p;
    int          lat;
    @(negedge clk);
    rst            = drv_rst;
    redirect_valid = drv_redir || (p_redir > 0 && $urandom_range(99) < p_redir);
    if (drv_redir)                  redirect_pc = drv_rpc;
    else if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
    else                            redirect_pc = $urandom;
    imem_req_ready = ($urandom_range(99) < p_mready);
    instr_ready    = ($urandom_range(99) < p_iready);
    rsp = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(pend_q[0].addr) : $urandom;
    #1;
    e_rv    = !rst && !redirect_valid && (pend_q.size() + buf_cnt < DEPTH);
    e_addr  = rst ? RPC : exp_pc;
    e_iv    = !rst && (buf_cnt > 0);
    e_pc    = e_iv ? exp_q[0] : 32'h0;
    e_instr = e_iv ? mem_word(exp_q[0]) : NOP_INSTR;
    chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
    chk("req_addr", imem_req_addr, e_addr);
    chk("instr_valid", 32'(instr_valid), 32'(e_iv));
    chk("instr_pc", instr_pc, e_pc);
    chk("instr", Instr, e_instr);
    // logs of observed DUT transfers
    if (imem_req_valid && imem_req_ready) begin
      acc_log.push_back(imem_req_addr); acc_cyc.push_back(cyc);
    end
    if (instr_valid && instr_ready && !redirect_valid && !rst) begin
      pop_log.push_back(instr_pc); pop_cyc.push_back(cyc);
    end
    // model update for this edge
    if (rsp) p = pend_q.pop_front();
    if (rst || redirect_valid) begin
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      exp_q.delete();
      buf_cnt = 0;
      exp_pc  = rst ? RPC : {redirect_pc[31:2], 2'b00};
    end else begin
      if (e_iv && instr_ready) begin
        void'(exp_q.pop_front());
        buf_cnt--;
      end
      if (rsp && !p.stale) buf_cnt++;
      if (e_rv && imem_req_ready) begin
        lat = $urandom_range(lat_max, lat_min);
        p.addr = exp_pc; p.due = cyc + lat; p.stale = 1'b0;
        if (p.due <= last_due) p.due = last_due + 1;
        last_due = p.due;
        pend_q.push_back(p);
        exp_q.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    drv_rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      chk("rst_instr", Instr, 32'h0000_0013);
      chk("rst_ivalid", 32'(instr_valid), 32'd0);
    end
    chk("rst_addr", imem_req_addr, RPC);
    chk("rst_pc", instr_pc, 32'h0);
    drv_rst = 1'b0;
  endtask

  task automatic set_knobs(input int lmin, input int lmax, input int mr, input int ir, input int rd);
    lat_min = lmin; lat_max = lmax; p_mready = mr; p_iready = ir; p_redir = rd;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int stale_seen;
    n_vec = 0; n_err = 0; cyc = 0; last_due = -1; buf_cnt = 0; exp_pc = RPC;
    drv_rst = 1'b1; drv_redir = 1'b0; drv_rpc = 32'h0;
    set_knobs(1, 1, 100, 100, 0);

    // basic stream with 1-cycle memory
    do_reset(3);
    clear_logs();
    run(8);
    chk("t1_nacc_ok", 32'(acc_log.size() >= 3), 32'd1);
    chk("t1_npop_ok", 32'(pop_log.size() >= 3), 32'd1);
    if (acc_log.size() >= 3 && pop_log.size() >= 3) begin
      chk("t1_acc0", acc_log[0], 32'h0);
      chk("t1_acc1", acc_log[1], 32'h4);
      chk("t1_acc2", acc_log[2], 32'h8);
      chk("t1_pop0", pop_log[0], 32'h0);
      chk("t1_pop1", pop_log[1], 32'h4);
      chk("t1_pop2", pop_log[2], 32'h8);
      chk("t1_latency", 32'(pop_cyc[0] - acc_cyc[0]), 32'd2);
      chk("t1_b2b", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
    end

    // decoder stalled: exactly DEPTH requests, then drain
    do_reset(6);
    clear_logs();
    set_knobs(1, 1, 100, 0, 0);
    run(8);
    chk("t2_nacc", 32'(acc_log.size()), 32'd2);
    chk("t2_req_off", 32'(imem_req_valid), 32'd0);
    set_knobs(1, 1, 100, 100, 0);
    run(6);
    chk("t2_npop_ok", 32'(pop_log.size() >= 2), 32'd1);
    if (pop_log.size() >= 2) begin
      chk("t2_pop0", pop_log[0], 32'h0);
      chk("t2_pop1", pop_log[1], 32'h4);
    end
    chk("t2_resume", 32'(acc_log.size() > 2), 32'd1);

    // redirect with two requests in flight, 3-cycle memory
    do_reset(6);
    clear_logs();
    set_knobs(3, 3, 100, 100, 0);
    run(2);
    drv_redir = 1'b1; drv_rpc = 32'h100;
    step();
    drv_redir = 1'b0;
    run(12);
    stale_seen = 0;
    foreach (pop_log[i]) if (pop_log[i] < 32'h100) stale_seen++;
    chk("t3_stale", 32'(stale_seen), 32'd0);
    chk("t3_npop_ok", 32'(pop_log.size() >= 1), 32'd1);
    if (pop_log.size() >= 1) chk("t3_first", pop_log[0], 32'h100);
    if (acc_log.size() >= 3) chk("t3_acc2", acc_log[2], 32'h100);

    // redirect coinciding with a response and a pop
    do_reset(6);
    clear_logs();
    set_knobs(1, 1, 100, 100, 0);
    run(2);
    drv_redir = 1'b1; drv_rpc = 32'h300;
    step();
    chk("t4_valid_at_redir", 32'(instr_valid), 32'd1);
    drv_redir = 1'b0;
    step();
    chk("t4_empty_after", 32'(instr_valid), 32'd0);
    run(6);
    if (pop_log.size() >= 1) chk("t4_first", pop_log[0], 32'h300);
    else chk("t4_npop", 32'(pop_log.size()), 32'd1);

    // unaligned redirect, then back-to-back redirects
    do_reset(6);
    drv_redir = 1'b1; drv_rpc = 32'h203;
    step();
    drv_redir = 1'b0;
    clear_logs();
    run(3);
    if (acc_log.size() >= 1) chk("t5_align", acc_log[0], 32'h200);
    else chk("t5_nacc", 32'(acc_log.size()), 32'd1);
    clear_logs();
    drv_redir = 1'b1; drv_rpc = 32'h40;
    step();
    drv_rpc = 32'h80;
    step();
    drv_redir = 1'b0;
    run(10);
    if (acc_log.size() >= 1 && pop_log.size() >= 2) begin
      chk("t5_last_acc", acc_log[0], 32'h80);
      chk("t5_last_pop0", pop_log[0], 32'h80);
      chk("t5_last_pop1", pop_log[1], 32'h84);
    end else chk("t5_activity", 32'(pop_log.size() >= 2 && acc_log.size() >= 1), 32'd1);

    // reset mid-stream with responses in flight
    set_knobs(1, 4, 70, 70, 0);
    run(40);
    do_reset(8);
    clear_logs();
    set_knobs(1, 1, 100, 100, 0);
    run(6);
    if (acc_log.size() >= 1 && pop_log.size() >= 1) begin
      chk("t6_restart_acc", acc_log[0], RPC);
      chk("t6_restart_pop", pop_log[0], RPC);
    end else chk("t6_activity", 32'(pop_log.size() >= 1 && acc_log.size() >= 1), 32'd1);

    // randomized traffic
    for (int seg = 0; seg < 20; seg++) begin
      int lmin;
      lmin = $urandom_range(2, 1);
      set_knobs(lmin, lmin + $urandom_range(3), $urandom_range(100, 30),
                $urandom_range(100, 30), $urandom_range(8));
      run(80);
      if (seg % 5 == 4) do_reset(8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
